cnt_pwm_gen: RTL and testbench
==============================

# cnt_pwm_gen

Downstream consumer of the free-running 8-bit counter. It turns the counter value into a single-channel PWM output with glitch-free duty updates: a valid/ready write is held in a shadow register and takes effect at counter wrap. It also reports wrap events, counts completed periods and flags any break in counter continuity. It sits directly after the counter instance in the timing chain, with `cnt` wired straight from the counter's output.

## Interface
Parameters:
- WIDTH, 8, width of `cnt` and of the duty value.
- PCW, 16, width of `period_count`.

Ports:
- clock  in  1  single clock for the whole block; same clock as the upstream counter.
- reset  in  1  synchronous, active-high reset.
- cnt  in  WIDTH  counter value from upstream, expected to advance by 1 per clock, mod 2^WIDTH.
- enable  in  1  PWM output enable.
- duty_valid  in  1  duty write request.
- duty_data  in  WIDTH  requested duty, in counts high per period.
- duty_ready  out  1  write can be accepted this cycle.
- pwm  out  1  registered PWM output.
- wrap  out  1  one-cycle pulse per detected counter wrap.
- period_count  out  PCW  number of wraps since reset.
- seq_err  out  1  sticky continuity-error flag.

## Operation
Internal state:
- cnt_q: previous sample of `cnt`.
- prev_valid: cnt_q holds a real sample.
- duty_shadow, pending: the accepted write waiting for a wrap.
- duty_active: the duty currently in use.

Wrap detection:
- wrap_det = prev_valid && cnt_q == 2^WIDTH-1 && cnt == 0.

Duty write handshake:
- duty_ready = !pending && !reset. This is combinational from registered state.
- A write is accepted when duty_valid && duty_ready. On acceptance, duty_shadow <= duty_data and pending <= 1.
- duty_data is ignored when no write is accepted. The master holds duty_valid until the write is accepted.

Duty load:
- On wrap_det && pending: duty_active <= duty_shadow and pending <= 0.
- A write accepted in the same cycle as wrap_det only fills the shadow. pending was 0 in that cycle, so nothing loads at that wrap. The new value loads at the following wrap.

PWM:
- duty_eff = (wrap_det && pending) ? duty_shadow : duty_active.
- pwm <= enable && (cnt < duty_eff), using an unsigned WIDTH-bit compare.
- Result: a new duty governs the period starting at the cnt==0 sample.
- duty 0 gives constant low. duty 2^WIDTH-1 gives high for every count except the top value. 100% duty is not representable.

Wrap and period counting:
- wrap <= wrap_det.
- On wrap_det, period_count <= period_count + 1, wrapping from 2^PCW-1 to 0. There is no saturation.

Continuity check:
- When prev_valid && cnt != cnt_q + 1 (mod 2^WIDTH): seq_err <= 1.
- seq_err stays set until reset. A skipped or stalled count does not produce wrap_det unless the max→0 pattern itself occurs.

Every cycle: cnt_q <= cnt and prev_valid <= 1.

## Timing
- Reset values: pwm 0, wrap 0, period_count 0, seq_err 0, duty_ready 0 (while reset is high), duty_active 0, pending 0, prev_valid 0.
- First cycle after reset deasserts:
  - duty_ready = 1.
  - No wrap or seq_err evaluation, because prev_valid = 0.
  - pwm follows cnt against duty 0, so it stays 0.
- Latency from a `cnt` sample to `pwm` and `wrap` is 1 clock. Latency to `seq_err` is also 1 clock.
- Write acceptance:
  - duty_ready drops the cycle after acceptance.
  - duty_ready rises the cycle after the loading wrap_det.
  - Maximum wait from acceptance to load is 2^WIDTH cycles.
- `enable` deasserted: pwm goes to 0 one cycle later. Wrap detection, duty loads and period counting continue.
- Reset mid-operation:
  - A pending write is discarded and duty_active returns to 0.
  - An upstream counter that keeps running without reset is re-acquired cleanly, with no false seq_err.

## Test plan
- Reset, then free-run `cnt` 0..255 repeatedly with no writes → pwm constantly 0; wrap pulses once every 256 cycles, one cycle after the cnt==0 sample; period_count reads 3 after 3 wraps.
- Write duty 64 mid-period (duty_valid=1 for one cycle) → duty_ready 0 on the next cycle; pwm high exactly for cnt samples 0..63 (64 cycles) of each later period; duty_ready back to 1 one cycle after the wrap.
- Write duty 255, then duty 0 → the first changes pwm to low for only the cnt=255 sample per period; the second turns pwm constantly low, starting at the next wrap.
- Write accepted in the same cycle as the cnt==0 wrap sample → duty_active unchanged for that period; the new duty applies from the following wrap.
- Force cnt 10→12 → seq_err 1 on the next cycle and stays 1 through further normal counting; a reset pulse clears it to 0.
- Accept duty 128, then assert reset before the wrap → after reset, pwm stays 0 through the next full period and duty_ready is 1.

Source files
------------

// File: rtl/cnt_pwm_gen_if.sv
// Duty-write handshake between a controller (master) and the PWM generator (slave).
interface cnt_pwm_gen_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             duty_valid;
  logic [WIDTH-1:0] duty_data;
  logic             duty_ready;

  modport master (
    output duty_valid,
    output duty_data,
    input  duty_ready
  );

  modport slave (
    input  duty_valid,
    input  duty_data,
    output duty_ready
  );
endinterface

// File: rtl/cnt_pwm_gen.sv
// Single-channel PWM driven by an upstream free-running counter. Duty writes are
// shadowed and take effect at counter wrap; also reports wraps, periods and continuity errors.
module cnt_pwm_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PCW   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    cnt,
  input  logic                enable,
  cnt_pwm_gen_if.slave        duty_if,
  output logic                pwm,
  output logic                wrap,
  output logic [PCW-1:0]      period_count,
  output logic                seq_err
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q;
  logic             prev_valid;
  logic [WIDTH-1:0] duty_shadow;
  logic             pending;
  logic [WIDTH-1:0] duty_active;

  logic             wrap_det_c;
  logic             duty_ready_c;
  logic             accept_c;
  logic             load_c;
  logic [WIDTH-1:0] duty_eff_c;
  logic [WIDTH-1:0] cnt_next_c;
  logic             seq_break_c;

  // Wrap/handshake/continuity decode from the current sample and registered state
  always_comb begin
    wrap_det_c   = prev_valid && (cnt_q == CNT_MAX) && (cnt == '0);
    duty_ready_c = !pending && !reset;
    accept_c     = duty_if.duty_valid && duty_ready_c;
    load_c       = wrap_det_c && pending;
    duty_eff_c   = load_c ? duty_shadow : duty_active;
    cnt_next_c   = cnt_q + WIDTH'(1);
    seq_break_c  = prev_valid && (cnt != cnt_next_c);
  end

  assign duty_if.duty_ready = duty_ready_c;

  // Accept and load are mutually exclusive: accept needs !pending, load needs pending
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      prev_valid   <= 1'b0;
      duty_shadow  <= '0;
      pending      <= 1'b0;
      duty_active  <= '0;
      pwm          <= 1'b0;
      wrap         <= 1'b0;
      period_count <= '0;
      seq_err      <= 1'b0;
    end else begin
      cnt_q      <= cnt;
      prev_valid <= 1'b1;
      if (accept_c) begin
        duty_shadow <= duty_if.duty_data;
        pending     <= 1'b1;
      end else if (load_c) begin
        duty_active <= duty_shadow;
        pending     <= 1'b0;
      end
      pwm  <= enable && (cnt < duty_eff_c);
      wrap <= wrap_det_c;
      if (wrap_det_c) begin
        period_count <= period_count + PCW'(1);
      end
      if (seq_break_c) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Directed bench for cnt_pwm_gen: per-cycle comparison against an arithmetic model,
// plus literal per-period expectations (pwm high counts, wrap counts, flags).
module tb_cnt_pwm_gen;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned PCW   = 16;
  localparam int CMOD = 256;
  localparam int PMOD = 65536;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] cnt = '0;
  logic             enable = 1'b0;
  logic             pwm;
  logic             wrap;
  logic [PCW-1:0]   period_count;
  logic             seq_err;

  cnt_pwm_gen_if #(.WIDTH(WIDTH)) duty_if ();

  cnt_pwm_gen #(.WIDTH(WIDTH), .PCW(PCW)) dut (
    .clock        (clock),
    .reset        (reset),
    .cnt          (cnt),
    .enable       (enable),
    .duty_if      (duty_if),
    .pwm          (pwm),
    .wrap         (wrap),
    .period_count (period_count),
    .seq_err      (seq_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int c_up     = 0;
  bit tb_en    = 1'b1;
  int hi_cnt   = 0;
  int wrap_cnt = 0;

  // Model state: last sample, pending write, active duty, period tally, error flag
  bit m_pvalid  = 1'b0;
  bit m_pending = 1'b0;
  bit m_err     = 1'b0;
  int m_prev    = 0;
  int m_shadow  = 0;
  int m_active  = 0;
  int m_periods = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: apply inputs, check ready, then check registered outputs after the edge
  task automatic step(input int c, input bit rst, input bit v, input int d);
    bit exp_ready;
    bit acc;
    bit w;
    int eff;
    int exp_pwm;
    @(negedge clock);
    reset  = rst;
    cnt    = WIDTH'(c);
    enable = tb_en;
    duty_if.duty_valid = v;
    duty_if.duty_data  = WIDTH'(d);
    #1;
    exp_ready = !m_pending && !rst;
    check("duty_ready", int'(duty_if.duty_ready), int'(exp_ready));
    acc = v && exp_ready;
    w   = m_pvalid && (m_prev == CMOD - 1) && (c == 0);
    eff = (w && m_pending) ? m_shadow : m_active;
    @(posedge clock);
    #1;
    if (rst) begin
      m_pvalid = 0; m_pending = 0; m_err = 0;
      m_active = 0; m_periods = 0; m_prev = c;
    end else begin
      if (m_pvalid && c != (m_prev + 1) % CMOD) m_err = 1;
      if (w) m_periods = (m_periods + 1) % PMOD;
      if (w && m_pending) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      if (acc) begin
        m_shadow  = d;
        m_pending = 1;
      end
      m_prev   = c;
      m_pvalid = 1;
    end
    exp_pwm = (!rst && tb_en && c < eff) ? 1 : 0;
    check("pwm", int'(pwm), exp_pwm);
    check("wrap", int'(wrap), int'(w && !rst));
    check("period_count", int'(period_count), m_periods);
    check("seq_err", int'(seq_err), int'(m_err));
    hi_cnt   += int'(pwm);
    wrap_cnt += int'(wrap);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(c_up, 1'b0, 1'b0, 0);
      c_up = (c_up + 1) % CMOD;
    end
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < CMOD && c_up != t; i++) run(1);
  endtask

  task automatic write_duty(input int d);
    step(c_up, 1'b0, 1'b1, d);
    c_up = (c_up + 1) % CMOD;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(c_up, 1'b1, 1'b0, 0);
      c_up = (c_up + 1) % CMOD;
    end
  endtask

  initial begin
    duty_if.duty_valid = 1'b0;
    duty_if.duty_data  = '0;

    // Reset, then three idle periods
    reset_cycles(3);
    check("reset_period_count", int'(period_count), 0);
    hi_cnt = 0; wrap_cnt = 0;
    run(768);
    check("idle_pwm_high", hi_cnt, 0);
    check("idle_wraps", wrap_cnt, 3);
    check("idle_period_count", int'(period_count), 3);

    // Duty 64 written mid-period
    run_to(100);
    write_duty(64);
    run_to(0);
    hi_cnt = 0;
    run(256);
    check("duty64_high", hi_cnt, 64);
    check("duty64_period_count", int'(period_count), 4);

    // Enable off: pwm low, wraps still counted
    tb_en = 1'b0;
    hi_cnt = 0; wrap_cnt = 0;
    run(256);
    check("disabled_high", hi_cnt, 0);
    check("disabled_wraps", wrap_cnt, 1);
    tb_en = 1'b1;

    // Duty 255 then duty 0
    run_to(50);
    write_duty(255);
    run_to(0);
    hi_cnt = 0;
    run(256);
    check("duty255_high", hi_cnt, 255);
    run_to(50);
    write_duty(0);
    run_to(0);
    hi_cnt = 0;
    run(256);
    check("duty0_high", hi_cnt, 0);

    // Write accepted on the wrap sample loads only at the following wrap
    write_duty(200);
    hi_cnt = 0;
    run(255);
    check("same_wrap_old_duty", hi_cnt, 0);
    hi_cnt = 0;
    run(256);
    check("same_wrap_new_duty", hi_cnt, 200);

    // Skip 10 -> 12: sticky error, cleared by reset, clean re-acquire
    run_to(10);
    run(1);
    c_up = 12;
    run(20);
    check("seq_err_sticky", int'(seq_err), 1);
    reset_cycles(1);
    check("seq_err_cleared", int'(seq_err), 0);
    run(300);
    check("seq_err_reacquire", int'(seq_err), 0);

    // Reset discards a pending write
    run_to(30);
    write_duty(128);
    run_to(60);
    reset_cycles(2);
    run_to(0);
    hi_cnt = 0;
    run(256);
    check("reset_discard_high", hi_cnt, 0);
    check("reset_discard_ready", int'(duty_if.duty_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
